// File: rtl/dmem_arbiter_if.sv
//==============================================================================
// Module      : dmem_arbiter_if
// Description : Bus bundle between the two memory masters, the arbiter and the
//               data memory control pins.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0;
  logic                  we0;
  logic                  byte0;
  logic [DATA_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;
  logic                  rerr0;

  logic                  req1;
  logic                  we1;
  logic                  byte1;
  logic [DATA_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  lock1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  rerr1;

  logic                  mem_we;
  logic                  mem_st_byte;
  logic                  mem_ld_byte;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  req0, we0, byte0, addr0, wdata0,
    input  req1, we1, byte1, addr1, wdata1, lock1,
    input  mem_rd,
    output gnt0, rvalid0, rdata0, rerr0,
    output gnt1, rvalid1, rdata1, rerr1,
    output mem_we, mem_st_byte, mem_ld_byte, mem_addr, mem_wd
  );

  modport master (
    output req0, we0, byte0, addr0, wdata0,
    output req1, we1, byte1, addr1, wdata1, lock1,
    output mem_rd,
    input  gnt0, rvalid0, rdata0, rerr0,
    input  gnt1, rvalid1, rdata1, rerr1,
    input  mem_we, mem_st_byte, mem_ld_byte, mem_addr, mem_wd
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//==============================================================================
// Module      : dmem_arbiter
// Description : Fixed-priority two-port data memory arbiter with starvation
//               guard for port 1, port-1 lock and registered responses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dmem_arbiter_if.slave  bus
);

  localparam int             CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  C_LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [0:0]     ST_OPEN   = 1'b0;
  localparam logic [0:0]     ST_LOCKED = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         starve_q, starve_d;
  logic                  rvalid0_q, rvalid1_q;
  logic                  rerr0_q, rerr1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                  w_gnt0, w_gnt1, w_any, w_illegal, w_go;
  logic                  w_sel_we, w_sel_byte;
  logic [DATA_WIDTH-1:0] w_sel_addr, w_sel_wdata, w_rd_data;
  logic [DATA_WIDTH:0]   w_end;

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (state_q == ST_LOCKED) begin
      w_gnt1 = bus.req1;
    end else if (bus.req1 && starve_q == C_LIMIT) begin
      w_gnt1 = 1'b1;
    end else if (bus.req0) begin
      w_gnt0 = 1'b1;
    end else if (bus.req1) begin
      w_gnt1 = 1'b1;
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_sel_we    = w_gnt1 ? bus.we1    : bus.we0;
  assign w_sel_byte  = w_gnt1 ? bus.byte1  : bus.byte0;
  assign w_sel_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

  // Last byte touched, one bit wider so the top-of-memory check never wraps.
  assign w_end = {1'b0, w_sel_addr} + (w_sel_byte ? '0 : (DATA_WIDTH+1)'(3));

  assign w_illegal = (!w_sel_byte && (w_sel_addr[1:0] != 2'b00)) ||
                     ((w_end >> ADDR_WIDTH) != '0);
  assign w_go      = w_any && !w_illegal;

  assign bus.mem_we      = w_go & w_sel_we;
  assign bus.mem_st_byte = w_go & w_sel_we & w_sel_byte;
  assign bus.mem_ld_byte = w_go & ~w_sel_we & w_sel_byte;
  assign bus.mem_addr    = w_go ? w_sel_addr  : '0;
  assign bus.mem_wd      = w_go ? w_sel_wdata : '0;

  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;

  always_comb begin
    state_d = state_q;
    if (w_gnt1) begin
      state_d = bus.lock1 ? ST_LOCKED : ST_OPEN;
    end else if (state_q == ST_LOCKED && !bus.req1) begin
      state_d = ST_OPEN;
    end
  end

  always_comb begin
    starve_d = '0;
    if (bus.req1 && !w_gnt1) begin
      starve_d = (starve_q == C_LIMIT) ? starve_q : starve_q + CW'(1);
    end
  end

  // Only legal reads return memory data; writes and errors respond with zero.
  assign w_rd_data = (w_go && !w_sel_we) ? bus.mem_rd : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OPEN;
      starve_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rerr0_q   <= 1'b0;
      rerr1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rvalid0_q <= w_gnt0;
      rvalid1_q <= w_gnt1;
      rerr0_q   <= w_gnt0 & w_illegal;
      rerr1_q   <= w_gnt1 & w_illegal;
      rdata0_q  <= w_gnt0 ? w_rd_data : '0;
      rdata1_q  <= w_gnt1 ? w_rd_data : '0;
    end
  end

  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rerr0   = rerr0_q;
  assign bus.rerr1   = rerr1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
//==============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a byte-array memory and
//               an abstract arbitration/memory reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dmem_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int SL   = 4;
  localparam int MEMB = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Requester stimulus, held until granted.
  logic        p_req   [2];
  logic        p_we    [2];
  logic        p_byte  [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];
  logic        p_lock1;

  assign bus.req0   = p_req[0];
  assign bus.we0    = p_we[0];
  assign bus.byte0  = p_byte[0];
  assign bus.addr0  = p_addr[0];
  assign bus.wdata0 = p_wdata[0];
  assign bus.req1   = p_req[1];
  assign bus.we1    = p_we[1];
  assign bus.byte1  = p_byte[1];
  assign bus.addr1  = p_addr[1];
  assign bus.wdata1 = p_wdata[1];
  assign bus.lock1  = p_lock1;

  // Memory attached to the arbiter, little-endian, combinational read.
  logic [7:0]    mem     [MEMB];
  logic [7:0]    ref_mem [MEMB];
  logic [AW-1:0] ma;
  assign ma = bus.mem_addr[AW-1:0];

  always_comb begin
    if (bus.mem_ld_byte) bus.mem_rd = {24'b0, mem[ma]};
    else bus.mem_rd = {mem[ma + AW'(3)], mem[ma + AW'(2)], mem[ma + AW'(1)], mem[ma]};
  end

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_st_byte) begin
        mem[ma] <= bus.mem_wd[7:0];
      end else begin
        mem[ma]          <= bus.mem_wd[7:0];
        mem[ma + AW'(1)] <= bus.mem_wd[15:8];
        mem[ma + AW'(2)] <= bus.mem_wd[23:16];
        mem[ma + AW'(3)] <= bus.mem_wd[31:24];
      end
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   nchecks = 0;
  int   nerrors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration rules plus a shadow byte memory.
  bit          m_locked = 1'b0;
  int          m_starve = 0;
  logic        e0, e1, ill;
  int          g;
  longint      la;
  logic [31:0] d;
  rsp_t        r_m;

  always @(negedge clk) begin
    if (rst) begin
      m_locked = 1'b0;
      m_starve = 0;
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (m_locked) e1 = p_req[1];
      else if (p_req[1] && m_starve == SL) e1 = 1'b1;
      else if (p_req[0]) e0 = 1'b1;
      else if (p_req[1]) e1 = 1'b1;
      chk("gnt{1,0}", {bus.gnt1, bus.gnt0}, {e1, e0});
      if (e0 || e1) begin
        g   = e1 ? 1 : 0;
        la  = longint'({32'b0, p_addr[g]});
        ill = (!p_byte[g] && (la % 4) != 0) || (la + (p_byte[g] ? 0 : 3) >= MEMB);
        d   = 32'h0;
        if (!ill && p_we[g]) begin
          if (p_byte[g]) begin
            ref_mem[la] = p_wdata[g][7:0];
          end else begin
            for (int k = 0; k < 4; k++) ref_mem[la + k] = p_wdata[g][8*k +: 8];
          end
        end else if (!ill) begin
          if (p_byte[g]) d = {24'b0, ref_mem[la]};
          else d = {ref_mem[la+3], ref_mem[la+2], ref_mem[la+1], ref_mem[la]};
        end
        chk("mem_ctl", {bus.mem_we, bus.mem_st_byte, bus.mem_ld_byte},
            ill ? 3'b000 : {p_we[g], p_we[g] & p_byte[g], ~p_we[g] & p_byte[g]});
        chk("mem_addr", bus.mem_addr, ill ? 32'h0 : p_addr[g]);
        chk("mem_wd", bus.mem_wd, ill ? 32'h0 : p_wdata[g]);
        r_m.cyc  = cyc;
        r_m.data = d;
        r_m.err  = ill;
        if (g == 0) q0.push_back(r_m);
        else q1.push_back(r_m);
      end else begin
        chk("mem_idle", {bus.mem_we, bus.mem_st_byte, bus.mem_ld_byte, bus.mem_addr, bus.mem_wd}, 0);
      end
      if (e1) m_locked = p_lock1;
      else if (m_locked && !p_req[1]) m_locked = 1'b0;
      if (p_req[1] && !e1) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
      else m_starve = 0;
    end
  end

  // Response monitor: a response is due exactly one cycle after its grant.
  rsp_t r0, r1;
  logic due0, due1;

  always @(negedge clk) begin
    if (!rst) begin
      due0 = (q0.size() > 0) && (q0[0].cyc + 1 == cyc);
      due1 = (q1.size() > 0) && (q1[0].cyc + 1 == cyc);
      chk("rvalid0", bus.rvalid0, due0);
      chk("rvalid1", bus.rvalid1, due1);
      if (due0) begin
        r0 = q0.pop_front();
        chk("rdata0", bus.rdata0, r0.data);
        chk("rerr0", bus.rerr0, r0.err);
      end
      if (due1) begin
        r1 = q1.pop_front();
        chk("rdata1", bus.rdata1, r1.data);
        chk("rerr1", bus.rerr1, r1.err);
      end
    end
  end

  // Called at 1 time unit after a rising edge; returns likewise.
  task automatic issue(input int p, input logic we, input logic by,
                       input logic [31:0] a, input logic [31:0] wd, input logic lk);
    int n;
    logic got;
    p_we[p]    = we;
    p_byte[p]  = by;
    p_addr[p]  = a;
    p_wdata[p] = wd;
    if (p == 1) p_lock1 = lk;
    p_req[p]   = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      n++;
      got = (p == 0) ? bus.gnt0 : bus.gnt1;
    end
    if (!got) begin
      nchecks++;
      nerrors++;
      $display("FAIL grant_timeout: port %0d got no grant, expected one within 64 cycles", p);
    end
    @(posedge clk);
    #1;
    p_req[p] = 1'b0;
    if (p == 1) p_lock1 = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int          r;
    int          gap;
    logic [31:0] a;
    logic        by;
    for (int i = 0; i < n; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      r  = $urandom_range(0, 19);
      by = ($urandom_range(0, 2) == 0);
      if (r < 14) begin
        a = 32'h100 + 32'($urandom_range(0, 63));
        if (r < 12) a[1:0] = 2'b00;
      end else if (r < 17) begin
        a = 32'h1FFF0 + 32'($urandom_range(0, 15));
        if (r == 14) a[1:0] = 2'b00;
      end else if (r < 19) begin
        a = $urandom();
      end else begin
        a = 32'hFFFF_FFFC;
      end
      issue(p, 1'($urandom_range(0, 1)), by, a, $urandom(),
            (p == 1) && ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < MEMB; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int p = 0; p < 2; p++) begin
      p_req[p]   = 1'b0;
      p_we[p]    = 1'b0;
      p_byte[p]  = 1'b0;
      p_addr[p]  = 32'h0;
      p_wdata[p] = 32'h0;
    end
    p_lock1 = 1'b0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {bus.rvalid1, bus.rvalid0, bus.rerr1, bus.rerr0, bus.gnt1, bus.gnt0}, 0);
    chk("rst_rdata", {bus.rdata1, bus.rdata0}, 0);
    rst = 1'b0;

    // Word write then read-back, byte write then byte and word reads.
    issue(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0);
    issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b1, 32'h103, 32'h55, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h103, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);

    // Both ports saturating the arbiter: starvation rotation.
    fork
      for (int i = 0; i < 12; i++) issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) issue(1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b0);
    join

    // Locked three-access sequence against a busy port 0.
    fork
      for (int i = 0; i < 10; i++) issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
      begin
        issue(1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
        issue(1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
        issue(1, 1'b0, 1'b0, 32'h108, 32'h0, 1'b0);
      end
    join

    // Misaligned word, word straddling the top, then confirm the top is untouched.
    issue(0, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h1FFFE, 32'h12345678, 1'b0);
    issue(0, 1'b0, 1'b0, 32'h1FFFC, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b1, 32'h1FFFF, 32'hA5, 1'b0);
    issue(0, 1'b0, 1'b0, 32'h1FFFC, 32'h0, 1'b0);

    // Asynchronous reset while locked with a port-1 response on the bus.
    issue(1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    issue(1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
    #2;
    chk("pre_rst_rvalid1", bus.rvalid1, 1'b1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("async_rst_rvalid1", bus.rvalid1, 1'b0);
    chk("async_rst_rdata1", bus.rdata1, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      issue(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
      issue(1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
    join

    fork
      rand_port(0, 300);
      rand_port(1, 300);
    join

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

endmodule

`default_nettype wire
